// File: rtl/biquad_iir_multicanal_pkg.sv
// biquad_iir_multicanal_pkg: shared FSM states and coefficient indices for the multichannel biquad
package biquad_iir_multicanal_pkg;
   typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;
   localparam int COEF_B0 = 0;
   localparam int COEF_B1 = 1;
   localparam int COEF_B2 = 2;
   localparam int COEF_A1 = 3;
   localparam int COEF_A2 = 4;
   localparam int N_COEF  = 5;
endpackage

// File: rtl/biquad_iir_multicanal_mac.sv
// biquad_iir_multicanal_mac: signed W x W multiply with add/subtract into a 2W+3 bit accumulator
//  clk, rst (async, active-low) | clr: zero acc | en: accumulate | sub: subtract product
//  a, b: signed operands | acc: accumulator value
module biquad_iir_multicanal_mac #(
   parameter int W = 25
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  sub,
   input  logic signed [W-1:0]   a,
   input  logic signed [W-1:0]   b,
   output logic signed [2*W+2:0] acc
);
   logic signed [2*W-1:0] prod;
   logic signed [2*W+2:0] prod_x, acc_d, acc_q;
   always_comb begin
      prod   = a * b;
      prod_x = {{3{prod[2*W-1]}}, prod};
      acc_d  = clr ? '0 : !en ? acc_q : sub ? acc_q - prod_x : acc_q + prod_x;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) acc_q <= '0;
      else      acc_q <= acc_d;
   assign acc = acc_q;
endmodule

// File: rtl/biquad_iir_multicanal.sv
// biquad_iir_multicanal: Direct-Form-I biquad, CH channels time-multiplexed over one multiplier
//  clk; rst (async, active-low); rx/u: sample strobe and packed inputs; clr: clear history and ovf
//  coef_we/coef_addr/coef_data: shadow coefficient write (0=b0 1=b1 2=b2 3=a1 4=a2)
//  rx_2/y: result strobe and packed outputs; busy: computation running; ovf: sticky overrun
module biquad_iir_multicanal
   import biquad_iir_multicanal_pkg::*;
#(
   parameter int W  = 25,
   parameter int F  = 15,
   parameter int CH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   input  logic [W*CH-1:0] u,
   input  logic            clr,
   input  logic            coef_we,
   input  logic [2:0]      coef_addr,
   input  logic [W-1:0]    coef_data,
   output logic            rx_2,
   output logic [W*CH-1:0] y,
   output logic            busy,
   output logic            ovf
);
   localparam int CW = CH > 1 ? $clog2(CH) : 1;
   localparam int AW = 2*W + 3;
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic signed [W-1:0]  UNITY   = W'(1) << F;
   state_t state_q, state_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [2:0] term_q, term_d;
   logic busy_q, busy_d, ovf_q, ovf_d, rx_2_q, rx_2_d;
   logic [W*CH-1:0] y_q, y_d;
   logic signed [W-1:0] x_q[CH], x_d[CH], x1_q[CH], x1_d[CH], x2_q[CH], x2_d[CH];
   logic signed [W-1:0] y1_q[CH], y1_d[CH], y2_q[CH], y2_d[CH];
   logic signed [W-1:0] coef_q[N_COEF], coef_d[N_COEF], shd_q[N_COEF], shd_d[N_COEF];
   logic mac_clr, mac_en, mac_sub;
   logic signed [W-1:0] mac_a, mac_b, res;
   logic signed [AW-1:0] acc, acc_sh;
   biquad_iir_multicanal_mac #(.W(W)) u_mac (
      .clk(clk), .rst(rst), .clr(mac_clr), .en(mac_en), .sub(mac_sub),
      .a(mac_a), .b(mac_b), .acc(acc)
   );
   // term order: b0*x, b1*x1, b2*x2, then a1*y1 and a2*y2 subtracted
   always_comb begin
      mac_a = term_q == 3'(COEF_B0) ? coef_q[COEF_B0] :
              term_q == 3'(COEF_B1) ? coef_q[COEF_B1] :
              term_q == 3'(COEF_B2) ? coef_q[COEF_B2] :
              term_q == 3'(COEF_A1) ? coef_q[COEF_A1] : coef_q[COEF_A2];
      mac_b = term_q == 3'(COEF_B0) ? x_q[ch_q] :
              term_q == 3'(COEF_B1) ? x1_q[ch_q] :
              term_q == 3'(COEF_B2) ? x2_q[ch_q] :
              term_q == 3'(COEF_A1) ? y1_q[ch_q] : y2_q[ch_q];
      mac_sub = term_q >= 3'(COEF_A1);
      acc_sh  = acc >>> F;
      res     = acc_sh > SAT_MAX ? SAT_MAX[W-1:0] : acc_sh < SAT_MIN ? SAT_MIN[W-1:0] : acc_sh[W-1:0];
   end
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      term_d  = term_q;
      busy_d  = busy_q;
      ovf_d   = ovf_q;
      rx_2_d  = 1'b0;
      y_d     = y_q;
      x_d     = x_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      y1_d    = y1_q;
      y2_d    = y2_q;
      coef_d  = coef_q;
      shd_d   = shd_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      for (int i = 0; i < N_COEF; i++)
         if (coef_we && coef_addr == 3'(i)) shd_d[i] = coef_data;
      if (clr) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         ovf_d   = 1'b0;
         mac_clr = 1'b1;
         for (int c = 0; c < CH; c++) begin
            x1_d[c] = '0;
            x2_d[c] = '0;
            y1_d[c] = '0;
            y2_d[c] = '0;
         end
      end else if (state_q == S_IDLE) begin
         if (rx) begin
            for (int c = 0; c < CH; c++) x_d[c] = u[c*W +: W];
            coef_d  = shd_q;
            busy_d  = 1'b1;
            state_d = S_MAC;
            ch_d    = '0;
            term_d  = '0;
            mac_clr = 1'b1;
         end
      end else begin
         // any rx outside IDLE, including the DONE cycle, is an overrun
         ovf_d = ovf_q | rx;
         if (state_q == S_MAC) begin
            mac_en  = 1'b1;
            term_d  = term_q + 3'd1;
            state_d = term_q == 3'(COEF_A2) ? S_STORE : S_MAC;
         end else if (state_q == S_STORE) begin
            mac_clr = 1'b1;
            term_d  = '0;
            for (int c = 0; c < CH; c++)
               if (CW'(c) == ch_q) begin
                  x2_d[c] = x1_q[c];
                  x1_d[c] = x_q[c];
                  y2_d[c] = y1_q[c];
                  y1_d[c] = res;
               end
            state_d = ch_q == CW'(CH-1) ? S_DONE : S_MAC;
            ch_d    = ch_q == CW'(CH-1) ? ch_q : ch_q + CW'(1);
         end else begin
            // y1 already holds each channel's fresh result
            for (int c = 0; c < CH; c++) y_d[c*W +: W] = y1_q[c];
            rx_2_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         term_q  <= '0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rx_2_q  <= 1'b0;
         y_q     <= '0;
         for (int c = 0; c < CH; c++) begin
            x_q[c]  <= '0;
            x1_q[c] <= '0;
            x2_q[c] <= '0;
            y1_q[c] <= '0;
            y2_q[c] <= '0;
         end
         for (int i = 0; i < N_COEF; i++) begin
            coef_q[i] <= i == COEF_B0 ? UNITY : '0;
            shd_q[i]  <= i == COEF_B0 ? UNITY : '0;
         end
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         term_q  <= term_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         rx_2_q  <= rx_2_d;
         y_q     <= y_d;
         x_q     <= x_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         y1_q    <= y1_d;
         y2_q    <= y2_d;
         coef_q  <= coef_d;
         shd_q   <= shd_d;
      end
   assign rx_2 = rx_2_q;
   assign y    = y_q;
   assign busy = busy_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_biquad_iir_multicanal.sv
// tb_biquad_iir_multicanal: directed self-checking bench for the multichannel biquad
module tb_biquad_iir_multicanal;
   localparam int W  = 25;
   localparam int CH = 2;
   logic clk = 1'b0, rst = 1'b0, rx = 1'b0, clr = 1'b0, coef_we = 1'b0;
   logic [2:0] coef_addr = '0;
   logic [W-1:0] coef_data = '0;
   logic [W*CH-1:0] u = '0, y;
   logic rx_2, busy, ovf;
   int ncmp = 0, nfail = 0, lat = 0, n2 = 0, first = 0;
   logic busy_acc = 1'b0;
   always #5 clk = ~clk;
   biquad_iir_multicanal dut (
      .clk(clk), .rst(rst), .rx(rx), .u(u), .clr(clr), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data), .rx_2(rx_2), .y(y), .busy(busy), .ovf(ovf)
   );
   function automatic longint ych(input int c);
      logic signed [W-1:0] v;
      v = y[c*W +: W];
      return longint'(v);
   endfunction
   task automatic chk(input string tag, input longint obs, input longint exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic wr(input int a, input int d);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 3'(a); coef_data = W'(d);
      @(negedge clk);
      coef_we = 1'b0;
   endtask
   task automatic pulse_clr();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask
   task automatic run(input string tag, input int u0, input int u1, input longint e0, input longint e1);
      @(negedge clk);
      rx = 1'b1; u = {W'(u1), W'(u0)};
      @(posedge clk); #1;
      rx = 1'b0;
      busy_acc = busy;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!rx_2 && lat < 30);
      chk({tag, "_lat"}, lat, 13);
      chk({tag, "_y0"}, ych(0), e0);
      chk({tag, "_y1"}, ych(1), e1);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_rx_2", rx_2, 0);
      chk("rst_y", y, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      run("pass", 1000, -5, 1000, -5);
      chk("pass_busy_acc", busy_acc, 1);
      chk("pass_busy_done", busy, 0);
      @(posedge clk); #1;
      chk("pass_rx_2_pulse", rx_2, 0);
      pulse_clr();
      wr(0, 16384); wr(1, 16384);
      run("fir0", 32768, 0, 16384, 0);
      run("fir1", 0, 0, 16384, 0);
      run("fir2", 0, 0, 0, 0);
      pulse_clr();
      wr(0, 32768); wr(1, 0); wr(3, -16384);
      run("rec0", 1000, 0, 1000, 0);
      run("rec1", 1000, 0, 1500, 0);
      run("rec2", 1000, 0, 1750, 0);
      run("rec3", 1000, 0, 1875, 0);
      pulse_clr();
      wr(1, 32768); wr(3, 0);
      run("satp0", 16777215, 0, 16777215, 0);
      run("satp1", 16777215, 0, 16777215, 0);
      run("satn0", -16777216, 0, -1, 0);
      run("satn1", -16777216, 0, -16777216, 0);
      pulse_clr();
      wr(1, 0);
      @(negedge clk);
      rx = 1'b1; u = {W'(9), W'(7)};
      @(posedge clk); #1;
      rx = 1'b0;
      n2 = 0; first = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rx_2) begin
            n2++;
            if (first == 0) first = i;
         end
         if (i == 4) begin rx = 1'b1; u = {W'(111), W'(222)}; end
         if (i == 5) rx = 1'b0;
      end
      chk("ovr_count", n2, 1);
      chk("ovr_lat", first, 13);
      chk("ovr_ovf", ovf, 1);
      chk("ovr_y0", ych(0), 7);
      chk("ovr_y1", ych(1), 9);
      pulse_clr();
      chk("ovr_clr_ovf", ovf, 0);
      @(negedge clk);
      rx = 1'b1; clr = 1'b1; u = {W'(5), W'(5)};
      @(negedge clk);
      rx = 1'b0; clr = 1'b0;
      n2 = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (rx_2 || busy) n2++;
      end
      chk("clrrx_idle", n2, 0);
      chk("clrrx_ovf", ovf, 0);
      chk("clrrx_y0", ych(0), 7);
      wr(0, 16384);
      @(negedge clk);
      rx = 1'b1; u = {W'(3), W'(1000)};
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rx_2", rx_2, 0);
      chk("mid_y", y, 0);
      chk("mid_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      run("post", 1000, -7, 1000, -7);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
